// File: rtl/multicycle_control_if.sv
// Bundle between the multicycle control unit and the datapath/memory.
//
// master modport : the control unit (takes en/opcode/funct/mem_ready,
//                  drives every control line plus status and debug state)
// slave modport  : the datapath side (the mirror image)
//
// Memory handshake: the control unit holds mem_read or mem_write high for
// as long as an access is pending; the access completes in the cycle where
// mem_ready is also high, and the unit moves on at the following edge.
// mem_ready is ignored in every cycle without a pending access.
interface multicycle_control_if #(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6,
    parameter int ALUCTL_W = 4,
    parameter int CNT_W    = 16
);
    logic                en;
    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT_W-1:0]  funct;
    logic                mem_ready;

    logic                ir_write;
    logic                pc_write;
    logic                pc_write_cond;
    logic                branch_ne;
    logic [1:0]          pc_src;
    logic                iord;
    logic                mem_read;
    logic                mem_write;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [ALUCTL_W-1:0] alu_ctl;
    logic                instr_done;
    logic                illegal;
    logic [CNT_W-1:0]    instr_count;
    logic [3:0]          state;

    modport master (
        input  en, opcode, funct, mem_ready,
        output ir_write, pc_write, pc_write_cond, branch_ne, pc_src, iord,
               mem_read, mem_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_ctl, instr_done, illegal,
               instr_count, state
    );

    modport slave (
        output en, opcode, funct, mem_ready,
        input  ir_write, pc_write, pc_write_cond, branch_ne, pc_src, iord,
               mem_read, mem_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_ctl, instr_done, illegal,
               instr_count, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle control unit for the MIPS-subset CPU.
//
// A Moore FSM sequences fetch / decode / execute / memory / writeback and
// drives the datapath control lines and ALU control from the current state.
// The only input-gated outputs are ir_write/pc_write in FETCH and the end
// of an SW in MEM_WR, both qualified by mem_ready.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high; returns to IDLE, clears the retired
//            counter and the sticky illegal flag
//   bus    - multicycle_control_if.master: en, opcode, funct, mem_ready in;
//            all control lines, instr_done, illegal, instr_count, and the
//            4-bit debug state out
module multicycle_control #(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6,
    parameter int ALUCTL_W = 4,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_control_if.master  bus
);
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EXEC_R   = 4'd3;
    localparam logic [3:0] S_R_WB     = 4'd4;
    localparam logic [3:0] S_EXEC_I   = 4'd5;
    localparam logic [3:0] S_I_WB     = 4'd6;
    localparam logic [3:0] S_MEM_ADDR = 4'd7;
    localparam logic [3:0] S_MEM_RD   = 4'd8;
    localparam logic [3:0] S_MEM_WB   = 4'd9;
    localparam logic [3:0] S_MEM_WR   = 4'd10;
    localparam logic [3:0] S_BRANCH   = 4'd11;
    localparam logic [3:0] S_JUMP     = 4'd12;
    localparam logic [3:0] S_HALT     = 4'd13;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(8'h00);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(8'h02);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(8'h04);
    localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(8'h05);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(8'h08);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(8'h23);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(8'h2B);

    localparam logic [FUNCT_W-1:0] FN_ADD = FUNCT_W'(8'h20);
    localparam logic [FUNCT_W-1:0] FN_SUB = FUNCT_W'(8'h22);
    localparam logic [FUNCT_W-1:0] FN_AND = FUNCT_W'(8'h24);
    localparam logic [FUNCT_W-1:0] FN_OR  = FUNCT_W'(8'h25);
    localparam logic [FUNCT_W-1:0] FN_SLT = FUNCT_W'(8'h2A);

    localparam logic [ALUCTL_W-1:0] ALU_ADD = ALUCTL_W'(4'b0010);
    localparam logic [ALUCTL_W-1:0] ALU_SUB = ALUCTL_W'(4'b0110);
    localparam logic [ALUCTL_W-1:0] ALU_AND = ALUCTL_W'(4'b0000);
    localparam logic [ALUCTL_W-1:0] ALU_OR  = ALUCTL_W'(4'b0001);
    localparam logic [ALUCTL_W-1:0] ALU_SLT = ALUCTL_W'(4'b0111);

    logic [3:0]          state_q;
    logic [3:0]          state_d;
    logic [OPCODE_W-1:0] op_q;
    logic [FUNCT_W-1:0]  fn_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                illegal_q;

    logic                instr_end;
    logic                funct_legal;
    logic [ALUCTL_W-1:0] alu_r;

    logic                ir_write;
    logic                pc_write;
    logic                pc_write_cond;
    logic                branch_ne;
    logic [1:0]          pc_src;
    logic                iord;
    logic                mem_read;
    logic                mem_write;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [ALUCTL_W-1:0] alu_ctl;

    // R-type ALU operation from the captured funct field.
    always_comb begin
        alu_r       = ALU_ADD;
        funct_legal = 1'b1;
        case (fn_q)
            FN_ADD:  alu_r = ALU_ADD;
            FN_SUB:  alu_r = ALU_SUB;
            FN_AND:  alu_r = ALU_AND;
            FN_OR:   alu_r = ALU_OR;
            FN_SLT:  alu_r = ALU_SLT;
            default: funct_legal = 1'b0;
        endcase
    end

    // Final cycle of an instruction; SW only finishes once the write lands.
    always_comb begin
        instr_end = (state_q == S_R_WB) || (state_q == S_I_WB) ||
                    (state_q == S_MEM_WB) || (state_q == S_BRANCH) ||
                    (state_q == S_JUMP) ||
                    ((state_q == S_MEM_WR) && bus.mem_ready);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (bus.en) state_d = S_FETCH;
            S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                // Live opcode here: the captured copy loads on this same edge.
                case (bus.opcode)
                    OP_RTYPE:      state_d = S_EXEC_R;
                    OP_ADDI:       state_d = S_EXEC_I;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    default:       state_d = S_HALT;
                endcase
            end
            S_EXEC_R:   state_d = funct_legal ? S_R_WB : S_HALT;
            S_EXEC_I:   state_d = S_I_WB;
            S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (bus.mem_ready) state_d = S_MEM_WB;
            S_HALT:     state_d = S_HALT;
            default:    state_d = state_q;
        endcase
        // en is only looked at between instructions, so a mid-instruction
        // drop lets the current one finish.
        if (instr_end) state_d = bus.en ? S_FETCH : S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (instr_end) cnt_q <= cnt_q + CNT_W'(1);
            if (state_d == S_HALT) illegal_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q <= '0;
            fn_q <= '0;
        end else if (state_q == S_DECODE) begin
            op_q <= bus.opcode;
            fn_q <= bus.funct;
        end
    end

    // Moore decode of the control lines. IDLE and HALT fall into the default
    // and keep everything, including alu_ctl, at zero.
    always_comb begin
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_src        = 2'b00;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_ctl       = '0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_ctl   = ALU_ADD;
                ir_write  = bus.mem_ready;
                pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_ctl   = ALU_ADD;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_ctl   = alu_r;
            end
            S_R_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                alu_ctl   = ALU_ADD;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctl   = ALU_ADD;
            end
            S_I_WB: begin
                reg_write = 1'b1;
                alu_ctl   = ALU_ADD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                alu_ctl  = ALU_ADD;
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                alu_ctl    = ALU_ADD;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                alu_ctl   = ALU_ADD;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_ctl       = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
                branch_ne     = (op_q == OP_BNE);
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
                alu_ctl  = ALU_ADD;
            end
            default: ;
        endcase
    end

    assign bus.ir_write      = ir_write;
    assign bus.pc_write      = pc_write;
    assign bus.pc_write_cond = pc_write_cond;
    assign bus.branch_ne     = branch_ne;
    assign bus.pc_src        = pc_src;
    assign bus.iord          = iord;
    assign bus.mem_read      = mem_read;
    assign bus.mem_write     = mem_write;
    assign bus.reg_dst       = reg_dst;
    assign bus.mem_to_reg    = mem_to_reg;
    assign bus.reg_write     = reg_write;
    assign bus.alu_src_a     = alu_src_a;
    assign bus.alu_src_b     = alu_src_b;
    assign bus.alu_ctl       = alu_ctl;
    assign bus.instr_done    = instr_end;
    assign bus.illegal       = illegal_q;
    assign bus.instr_count   = cnt_q;
    assign bus.state         = state_q;
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Parameterised multicycle control unit for the MIPS-subset CPU. It replaces the single-cycle opcode decoder with a Moore state machine that sequences fetch, decode, execute, memory and writeback, and stalls on a memory ready handshake. It drives all datapath control signals and ALU control directly. It also flags illegal instructions and counts retired instructions.

Parameters:
OPCODE_W, 6, opcode field width
FUNCT_W, 6, funct field width (full 6-bit funct)
ALUCTL_W, 4, ALU control width
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
en  in  1  run enable; sampled only in IDLE and at the end of an instruction
opcode  in  OPCODE_W  instruction register bits [31:26]
funct  in  FUNCT_W  instruction register bits [5:0]
mem_ready  in  1  memory has completed the current access this cycle
ir_write  out  1  load the instruction register
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if the branch condition is met
branch_ne  out  1  branch condition: 1 = zero flag low (BNE), 0 = zero flag high (BEQ)
pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut register, 10 = jump target
iord  out  1  memory address source: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
reg_dst  out  1  write register: 0 = rt, 1 = rd
mem_to_reg  out  1  write data: 0 = ALUOut, 1 = MDR
reg_write  out  1  register file write enable
alu_src_a  out  1  ALU A input: 0 = PC, 1 = register A
alu_src_b  out  2  ALU B input: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2
alu_ctl  out  ALUCTL_W  ALU operation: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
instr_done  out  1  one-cycle pulse on the final state of each instruction
illegal  out  1  sticky illegal-instruction flag
instr_count  out  CNT_W  count of retired instructions; wraps modulo 2^CNT_W
state  out  4  current state encoding, for debug

Behaviour:
- Reset is asynchronous. It forces the state to IDLE and clears instr_count and illegal. With state = IDLE, every control output is 0.
- All control outputs are a Moore decode of the current state. The only exceptions are the gated signals in FETCH (see below).
- Any signal not listed for a state is 0. alu_ctl is 0010 unless a state states otherwise.
- opcode and funct are captured into internal registers on the DECODE cycle. All later states use the captured copies.
- IDLE: go to FETCH if en = 1.
- FETCH: mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, pc_src = 00.
  - ir_write and pc_write are asserted only when mem_ready = 1.
  - Stay in FETCH while mem_ready = 0. Go to DECODE when mem_ready = 1.
- DECODE: alu_src_a = 0, alu_src_b = 11 (computes the branch target).
  - Next state by opcode:
    - 0x00 -> EXEC_R
    - 0x08 -> EXEC_I
    - 0x23 or 0x2B -> MEM_ADDR
    - 0x04 or 0x05 -> BRANCH
    - 0x02 -> JUMP
    - any other opcode -> HALT
- EXEC_R: alu_src_a = 1, alu_src_b = 00.
  - alu_ctl from funct: 0x20 -> 0010, 0x22 -> 0110, 0x24 -> 0000, 0x25 -> 0001, 0x2A -> 0111.
  - Go to R_WB. Any other funct -> HALT.
- R_WB: reg_dst = 1, mem_to_reg = 0, reg_write = 1. Instruction ends here.
- EXEC_I: alu_src_a = 1, alu_src_b = 10. Go to I_WB.
- I_WB: reg_dst = 0, mem_to_reg = 0, reg_write = 1. Instruction ends here.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10. Go to MEM_RD for opcode 0x23, MEM_WR for 0x2B.
- MEM_RD: mem_read = 1, iord = 1. Stay while mem_ready = 0, then go to MEM_WB.
- MEM_WB: reg_dst = 0, mem_to_reg = 1, reg_write = 1. Instruction ends here.
- MEM_WR: mem_write = 1, iord = 1. Stay while mem_ready = 0. The instruction ends on the cycle mem_ready = 1.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_ctl = 0110, pc_write_cond = 1, pc_src = 01.
  - branch_ne = 1 if the captured opcode is 0x05. Instruction ends here.
- JUMP: pc_write = 1, pc_src = 10. Instruction ends here.
- Instruction end:
  - instr_done = 1 for that one cycle, and instr_count increments on that clock edge.
  - Next state is FETCH if en = 1, otherwise IDLE.
  - Deasserting en mid-instruction does not abort the instruction; it completes first.
- HALT: illegal is set on entry and stays set. All control outputs are 0 and instr_done = 0. Only reset leaves HALT.
- Latency with mem_ready tied to 1 (cycles): R-type 4, ADDI 4, LW 5, SW 4, BEQ/BNE 3, J 3. Each cycle mem_ready is held low adds one cycle.
- Reset asserted mid-instruction: all outputs drop to their IDLE values immediately, without waiting for a clock edge. Nothing partial is retired.

Test Plan:
- Reset then en = 1, mem_ready = 1, opcode 0x00, funct 0x22 -> states FETCH, DECODE, EXEC_R (alu_ctl = 0110), R_WB (reg_write = 1, reg_dst = 1); instr_done pulses at cycle 4; instr_count = 1.
- LW (opcode 0x23) with mem_ready low for 2 cycles in MEM_RD -> 7 cycles total; MEM_WB has mem_to_reg = 1; ir_write is asserted only on the mem_ready cycle of FETCH.
- BNE (opcode 0x05) -> BRANCH asserts pc_write_cond = 1, branch_ne = 1, pc_src = 01, alu_ctl = 0110; BEQ (opcode 0x04) gives branch_ne = 0.
- opcode 0x3F, and separately opcode 0x00 with funct 0x03 -> HALT, illegal = 1, stays there for 20 cycles; reset clears illegal.
- J (opcode 0x02) with en dropped during DECODE -> JUMP completes (pc_write = 1, pc_src = 10), then IDLE with all outputs 0.
- CNT_W = 2, five back-to-back J instructions -> instr_count sequence 1, 2, 3, 0, 1; assert reset during MEM_WR -> outputs 0 immediately and instr_count = 0.
